// File: rtl/rps_referee_if.sv
// rps_referee_if: predictor handshake between the referee (master) and the AI predictor (slave).
interface rps_referee_if;
  logic       predict_req;
  logic       predict_valid;
  logic [1:0] ai_sel;
  modport master (output predict_req, input predict_valid, input ai_sel);
  modport slave (input predict_req, output predict_valid, output ai_sel);
endinterface

// File: rtl/rps_referee.sv
// rps_referee: rock-paper-scissors round controller; fetches the AI move, takes the key press, judges and scores.
module rps_referee #(
  parameter int MAX_ROUNDS = 60,
  parameter int SCORE_W    = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_play_n,
  input  logic [1:0]         i_player_sel,
  rps_referee_if.master      pif,
  output logic [3:0]         o_combination,
  output logic               o_round_done,
  output logic [1:0]         o_reward,
  output logic               o_bad_move,
  output logic [SCORE_W-1:0] o_player_score,
  output logic [SCORE_W-1:0] o_ai_score,
  output logic [SCORE_W-1:0] o_tie_count,
  output logic [SCORE_W-1:0] o_round_count,
  output logic               o_match_over
);
  typedef enum logic [2:0] {S_REQ, S_ARMED, S_JUDGE, S_REPORT, S_DONE} state_t;
  localparam logic [SCORE_W-1:0] MAX_CNT = SCORE_W'(MAX_ROUNDS);
  state_t             r_state, w_next;
  logic               r_run, r_s1, r_s2, r_s3, r_press;
  logic [1:0]         r_ai_move, r_player_move, r_reward;
  logic [3:0]         r_comb;
  logic [SCORE_W-1:0] r_player_score, r_ai_score, r_tie_count, r_round_count;
  logic               w_req, w_bad, w_done, w_take_ai, w_take_player;
  logic [1:0]         w_beaten, w_reward;
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
  // the move that ai_move defeats: rock>scissor>paper>rock
  assign w_beaten = (r_ai_move == 2'b10) ? 2'b00 : r_ai_move + 2'b01;
  assign w_reward = (r_ai_move == r_player_move) ? 2'b00 : (r_player_move == w_beaten) ? 2'b01 : 2'b10;
  assign w_take_ai = (r_state == S_REQ) && r_run && pif.predict_valid;
  assign w_take_player = (r_state == S_ARMED) && r_press && !(&i_player_sel);
  always_comb begin
    w_next = r_state;
    w_req  = 1'b0;
    w_bad  = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      S_REQ: begin
        w_req  = r_run;
        w_next = w_take_ai ? S_ARMED : S_REQ;
      end
      S_ARMED: begin
        w_bad  = r_press && (&i_player_sel);
        w_next = w_take_player ? S_JUDGE : S_ARMED;
      end
      S_JUDGE: w_next = S_REPORT;
      S_REPORT: begin
        w_done = 1'b1;
        w_next = (r_round_count == MAX_CNT) ? S_DONE : S_REQ;
      end
      default: w_next = S_DONE;
    endcase
  end
  // r_run holds predict_req low until the first clock after reset release
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state        <= S_REQ;
      r_run          <= 1'b0;
      r_s1           <= 1'b1;
      r_s2           <= 1'b1;
      r_s3           <= 1'b1;
      r_press        <= 1'b0;
      r_ai_move      <= 2'b00;
      r_player_move  <= 2'b00;
      r_reward       <= 2'b00;
      r_comb         <= 4'b0000;
      r_player_score <= '0;
      r_ai_score     <= '0;
      r_tie_count    <= '0;
      r_round_count  <= '0;
    end else begin
      r_state        <= w_next;
      r_run          <= 1'b1;
      r_s1           <= i_play_n;
      r_s2           <= r_s1;
      r_s3           <= r_s2;
      r_press        <= r_s3 & ~r_s2;
      r_ai_move      <= w_take_ai ? ((&pif.ai_sel) ? 2'b00 : pif.ai_sel) : r_ai_move;
      r_player_move  <= w_take_player ? i_player_sel : r_player_move;
      if (r_state == S_JUDGE) begin
        r_reward       <= w_reward;
        r_comb         <= {r_ai_move, r_player_move};
        r_player_score <= (w_reward == 2'b10) ? sat_inc(r_player_score) : r_player_score;
        r_ai_score     <= (w_reward == 2'b01) ? sat_inc(r_ai_score) : r_ai_score;
        r_tie_count    <= (w_reward == 2'b00) ? sat_inc(r_tie_count) : r_tie_count;
        r_round_count  <= sat_inc(r_round_count);
      end
    end
  end
  assign pif.predict_req   = w_req;
  assign o_combination     = r_comb;
  assign o_round_done      = w_done;
  assign o_reward          = r_reward;
  assign o_bad_move        = w_bad;
  assign o_player_score    = r_player_score;
  assign o_ai_score        = r_ai_score;
  assign o_tie_count       = r_tie_count;
  assign o_round_count     = r_round_count;
  assign o_match_over      = (r_round_count == MAX_CNT);
endmodule
